// File: rtl/malu_mult_pkg.sv
// ============================================================================
// Module   : malu_mult_pkg
// Brief    : Shared types and constants for the mALU shift-and-add multiplier
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package malu_mult_pkg;

  // Default operand width; the product is twice this wide.
  localparam int DEFAULT_WIDTH = 8;

  // Control states, 2-bit binary encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : malu_mult_pkg

`default_nettype wire

// File: rtl/mult_shreg.sv
// ============================================================================
// Module   : mult_shreg
// Brief    : WIDTH-bit right shift register with parallel load, shift enable
//            and LSB tap. Load has priority over shift; shifting fills with 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] shreg_q;

  // Parallel load or zero-filling right shift, cleared by async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= d_i;
    end else if (shift_i) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  assign lsb_o = shreg_q[0];

endmodule : mult_shreg

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module   : shift_add_multiplier
// Brief    : Sequential unsigned shift-and-add multiplier, one bit-step per
//            clock. Fixed latency of WIDTH+1 edges from start to done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier
  import malu_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Step counter width is derived from WIDTH and is not meant to be overridden.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               w_mplier_lsb;
  logic               w_accept;
  logic               w_run;
  logic               w_last_step;

  assign w_accept    = (state_q == ST_IDLE) && start;
  assign w_run       = (state_q == ST_RUN);
  assign w_last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Multiplier operand: loaded on an accepted start, shifted right each RUN step.
  mult_shreg #(
    .WIDTH (WIDTH)
  ) u_mplier (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_accept),
    .shift_i (w_run),
    .d_i     (multiplier),
    .lsb_o   (w_mplier_lsb)
  );

  // Accumulator next value: add the shifted multiplicand when the multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (w_mplier_lsb) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Control FSM with datapath registers and registered busy/done/product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= {{WIDTH{1'b0}}, multiplicand};
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          // The last step commits the sum including its own add.
          if (w_last_step) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule : shift_add_multiplier

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module   : tb_shift_add_multiplier
// Brief    : Directed self-checking bench for shift_add_multiplier (WIDTH=8)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, count busy cycles, check the done cycle and product.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input string tag);
    int nb;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    tick();
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    nb = 0;
    while (busy && nb < 40) begin
      check({tag, "_nodone_in_run"}, 32'(done), 32'd0);
      nb++;
      tick();
    end
    check({tag, "_busy_len"}, 32'(nb), 32'(W));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_product"}, 32'(product), 32'(exp));
    tick();
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int nd;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    reset = 1'b0;
    tick();

    // 1: 13 * 11
    do_op(8'd13, 8'd11, 16'h008F, "t1_13x11");

    // 2: extremes and zero operand
    do_op(8'd255, 8'd255, 16'hFE01, "t2_255x255");
    do_op(8'd0, 8'd200, 16'h0000, "t2_0x200");

    // 3: 1 * 200 with start pulses during RUN that must be ignored
    start        = 1'b1;
    multiplicand = 8'd1;
    multiplier   = 8'd200;
    tick();
    for (int c = 1; c <= W; c++) begin
      start        = (c == 2 || c == 5);
      multiplicand = 8'd3;
      multiplier   = 8'd3;
      tick();
    end
    start = 1'b0;
    check("t3_done", 32'(done), 32'd1);
    check("t3_product", 32'(product), 32'h00C8);
    tick();
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_idle_done", 32'(done), 32'd0);
    tick();

    // 4: start held high, back-to-back operations
    start        = 1'b1;
    multiplicand = 8'd2;
    multiplier   = 8'd3;
    tick();
    multiplicand = 8'd4;
    multiplier   = 8'd5;
    n = 0;
    while (!done && n < 40) begin
      n++;
      tick();
    end
    check("t4_first_done", 32'(done), 32'd1);
    check("t4_first_product", 32'(product), 32'h0006);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 5) begin
        check("t4_busy_mid", 32'(busy), 32'd1);
        check("t4_prev_product_held", 32'(product), 32'h0006);
      end
    end while (!done && n < 40);
    check("t4_done_spacing", 32'(n), 32'd10);
    check("t4_second_product", 32'(product), 32'h0014);
    start = 1'b0;
    tick();
    tick();

    // 5: asynchronous reset in the middle of RUN
    start        = 1'b1;
    multiplicand = 8'd100;
    multiplier   = 8'd100;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_product", 32'(product), 32'd0);
    #1;
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) nd++;
    end
    check("t5_no_done_after_abort", 32'(nd), 32'd0);
    do_op(8'd7, 8'd9, 16'h003F, "t5_7x9");

    // 6: random operands against a*b
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      do_op(ra, rb, 16'(ra) * 16'(rb), $sformatf("t6_rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_shift_add_multiplier

`default_nettype wire
